// File: rtl/id_stage_pkg.sv
// Shared MIPS opcode/function encodings and field widths for the decode stage and ALU.
package id_stage_pkg;

  localparam int OP_W  = 6;
  localparam int REG_W = 5;
  localparam int FN_W  = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b00_0000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b00_1000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b00_0100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b00_0101;
  localparam logic [OP_W-1:0] OP_SW    = 6'b10_1011;

  localparam logic [FN_W-1:0] FN_SLL   = 6'b00_0000;
  localparam logic [FN_W-1:0] FN_SRL   = 6'b00_0010;
  localparam logic [FN_W-1:0] FN_SRA   = 6'b00_0011;
  localparam logic [FN_W-1:0] FN_MULT  = 6'b01_1000;
  localparam logic [FN_W-1:0] FN_MULTU = 6'b01_1001;
  localparam logic [FN_W-1:0] FN_DIV   = 6'b01_1010;
  localparam logic [FN_W-1:0] FN_DIVU  = 6'b01_1011;
  localparam logic [FN_W-1:0] FN_ADD   = 6'b10_0000;

  // Shifts take the shifted value from rt, so the operand order is swapped.
  function automatic logic is_shift(input logic [FN_W-1:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

  function automatic logic is_muldiv(input logic [FN_W-1:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  function automatic logic is_nodst_itype(input logic [OP_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/id_stage_gpr_file.sv
// General-purpose register file: two async read ports, one sync write port, R0 reads 0.
// Define BYPASS_EN for write-first reads of an index being written this cycle.
module gpr_file #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (raddr_a == '0) rdata_a = '0;
`ifdef BYPASS_EN
    else if (we && (waddr == raddr_a)) rdata_a = wdata;
`endif
    if (raddr_b == '0) rdata_b = '0;
`ifdef BYPASS_EN
    else if (we && (waddr == raddr_b)) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// Decode/operand-fetch stage: decode mux, single-entry output register, valid/ready handshake.
// Define BYPASS_EN to forward writeback data into reads and into a stalled held entry.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic                     wb_en,
  input  logic [$clog2(NREG)-1:0]  wb_addr,
  input  logic [DW-1:0]            wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              i_datain,
  output logic [DW-1:0]            gr1,
  output logic [DW-1:0]            gr2,
  output logic [$clog2(NREG)-1:0]  dst
);

  localparam int AW = $clog2(NREG);

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rs, rt, rd;
  logic [FN_W-1:0]  fn;
  logic [AW-1:0]    sel_a, sel_b, dst_dec;
  logic [DW-1:0]    rd_a, rd_b;
  logic             accept;

  assign op = in_instr[31:26];
  assign rs = in_instr[25:21];
  assign rt = in_instr[20:16];
  assign rd = in_instr[15:11];
  assign fn = in_instr[5:0];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sel_a   = AW'(rs);
    sel_b   = AW'(rt);
    dst_dec = AW'(rt);
    if (op == OP_RTYPE) begin
      dst_dec = AW'(rd);
      if (is_shift(fn)) begin
        sel_a = AW'(rt);
        sel_b = AW'(rs);
      end
      if (is_muldiv(fn)) dst_dec = '0;
    end else if (is_nodst_itype(op)) begin
      dst_dec = '0;
    end
  end

  gpr_file #(.DW(DW), .NREG(NREG), .AW(AW)) u_gpr (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (sel_a),
    .raddr_b (sel_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

`ifdef BYPASS_EN
  // Source indices of the held entry, kept so a stalled entry can be refreshed.
  logic [AW-1:0] src_a, src_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      i_datain  <= '0;
      gr1       <= '0;
      gr2       <= '0;
      dst       <= '0;
`ifdef BYPASS_EN
      src_a     <= '0;
      src_b     <= '0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      i_datain  <= in_instr;
      gr1       <= rd_a;
      gr2       <= rd_b;
      dst       <= dst_dec;
`ifdef BYPASS_EN
      src_a     <= sel_a;
      src_b     <= sel_b;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
`ifdef BYPASS_EN
    end else if (out_valid && wb_en && (wb_addr != '0)) begin
      if (wb_addr == src_a) gr1 <= wb_data;
      if (wb_addr == src_b) gr2 <= wb_data;
`endif
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic vs a register-level model.
// Build with or without BYPASS_EN to match the RTL configuration.
module tb_id_stage;

`ifdef BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst, in_valid, out_ready, wb_en;
  logic [31:0] in_instr, wb_data;
  logic [4:0]  wb_addr;
  logic        in_ready, out_valid;
  logic [31:0] i_datain, gr1, gr2;
  logic [4:0]  dst;

  int checks = 0;
  int errors = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .i_datain(i_datain), .gr1(gr1), .gr2(gr2), .dst(dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
  endtask

  // R-type add word: rd <- rs + rt
  function automatic logic [31:0] add_w(input int rdv, input int rsv, input int rtv);
    return {6'd0, 5'(rsv), 5'(rtv), 5'(rdv), 5'd0, 6'h20};
  endfunction

  task automatic test_reset;
    idle(); rst = 1'b1; in_instr = '0;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", out_valid); end
    checks++; if (gr1 !== 32'd0 || gr2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_ops got %h/%h expected 0/0", gr1, gr2); end
    checks++; if (dst !== 5'd0 || i_datain !== 32'd0) begin errors++; $display("[TB] FAIL reset_dst got %0d/%h expected 0/0", dst, i_datain); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); end
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_instr = add_w(1, i, 31 - i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || gr1 !== 32'd0 || gr2 !== 32'd0 || dst !== 5'd1) begin
        errors++; $display("[TB] FAIL reset_gpr%0d got v=%b %h/%h d=%0d expected v=1 0/0 d=1", i, out_valid, gr1, gr2, dst);
      end
    end
    idle(); tick();
  endtask

  task automatic test_sll;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDDDD_DDDD;
    tick();
    wb_en = 1'b0; in_valid = 1'b1; in_instr = 32'h0001_1040;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sll_valid got %b expected 1", out_valid); end
    checks++; if (gr1 !== 32'hDDDD_DDDD) begin errors++; $display("[TB] FAIL sll_gr1 got %h expected dddddddd", gr1); end
    checks++; if (gr2 !== 32'd0) begin errors++; $display("[TB] FAIL sll_gr2 got %h expected 0", gr2); end
    checks++; if (dst !== 5'd2) begin errors++; $display("[TB] FAIL sll_dst got %0d expected 2", dst); end
    checks++; if (i_datain !== 32'h0001_1040) begin errors++; $display("[TB] FAIL sll_instr got %h expected 00011040", i_datain); end
    tick();
  endtask

  task automatic test_add;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hC040_4040;
    tick();
    wb_addr = 5'd2; wb_data = 32'hFFFF_FFFF;
    tick();
    wb_en = 1'b0; in_valid = 1'b1; in_instr = 32'h0022_1820;
    tick();
    in_valid = 1'b0;
    checks++; if (gr1 !== 32'hC040_4040) begin errors++; $display("[TB] FAIL add_gr1 got %h expected c0404040", gr1); end
    checks++; if (gr2 !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL add_gr2 got %h expected ffffffff", gr2); end
    checks++; if (dst !== 5'd3 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_dst got %0d v=%b expected 3 v=1", dst, out_valid); end
    tick();
  endtask

  task automatic test_stall;
    in_valid = 1'b1; in_instr = 32'h0022_1820;
    tick();
    out_ready = 1'b0; in_instr = 32'h0041_2020;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready%0d got %b expected 0", k, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || i_datain !== 32'h0022_1820 || gr1 !== 32'hC040_4040 || gr2 !== 32'hFFFF_FFFF || dst !== 5'd3) begin
        errors++; $display("[TB] FAIL stall_hold%0d got v=%b %h %h/%h d=%0d expected v=1 00221820 c0404040/ffffffff d=3", k, out_valid, i_datain, gr1, gr2, dst);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || i_datain !== 32'h0041_2020 || gr1 !== 32'hFFFF_FFFF || gr2 !== 32'hC040_4040 || dst !== 5'd4) begin
      errors++; $display("[TB] FAIL release_next got v=%b %h %h/%h d=%0d expected v=1 00412020 ffffffff/c0404040 d=4", out_valid, i_datain, gr1, gr2, dst);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL no_duplicate got %b expected 0", out_valid); end
  endtask

  task automatic test_r0;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
    in_valid = 1'b1; in_instr = 32'h0000_0820;
    tick();
    wb_en = 1'b0;
    checks++; if (gr1 !== 32'd0 || gr2 !== 32'd0) begin errors++; $display("[TB] FAIL r0_same_cycle got %h/%h expected 0/0", gr1, gr2); end
    tick();
    in_valid = 1'b0;
    checks++; if (gr1 !== 32'd0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL r0_read got %h v=%b expected 0 v=1", gr1, out_valid); end
    tick();
  endtask

  task automatic test_bypass;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_0055;
    tick();
    wb_addr = 5'd5; wb_data = 32'h0000_A5A5;
    tick();
    wb_addr = 5'd4; wb_data = 32'd1; in_valid = 1'b1; in_instr = 32'h2085_00D0;
    tick();
    in_valid = 1'b0; wb_en = 1'b0;
    checks++; if (gr1 !== (BYP ? 32'd1 : 32'h55)) begin errors++; $display("[TB] FAIL byp_accept_gr1 got %h expected %h", gr1, BYP ? 32'd1 : 32'h55); end
    checks++; if (gr2 !== 32'h0000_A5A5 || dst !== 5'd5) begin errors++; $display("[TB] FAIL byp_accept_gr2 got %h d=%0d expected 0000a5a5 d=5", gr2, dst); end
    out_ready = 1'b0; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'd7;
    tick();
    wb_en = 1'b0;
    checks++; if (gr1 !== (BYP ? 32'd7 : 32'h55) || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL byp_stall_gr1 got %h v=%b expected %h v=1", gr1, out_valid, BYP ? 32'd7 : 32'h55); end
    tick();
    checks++; if (gr1 !== (BYP ? 32'd7 : 32'h55) || gr2 !== 32'h0000_A5A5) begin errors++; $display("[TB] FAIL byp_hold got %h/%h expected %h/0000a5a5", gr1, gr2, BYP ? 32'd7 : 32'h55); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL byp_drain got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; in_instr = 32'h0022_1820;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || gr1 !== 32'd0 || i_datain !== 32'd0) begin errors++; $display("[TB] FAIL reset_mid got v=%b %h %h expected v=0 0 0", out_valid, gr1, i_datain); end
    in_valid = 1'b1; in_instr = 32'h0022_1820;
    tick();
    in_valid = 1'b0;
    checks++; if (gr1 !== 32'd0 || gr2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_mid_gpr got %h/%h expected 0/0", gr1, gr2); end
    tick();
  endtask

  logic [31:0] mreg [32];

  // Operand sources and destination straight from the instruction-set rules.
  function automatic void ref_decode(input logic [31:0] ins, output logic [4:0] s1,
                                     output logic [4:0] s2, output logic [4:0] d);
    logic [5:0] op, fn;
    op = ins[31:26]; fn = ins[5:0];
    s1 = ins[25:21]; s2 = ins[20:16]; d = ins[20:16];
    if (op == 6'd0) begin
      d = ins[15:11];
      if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) begin s1 = ins[20:16]; s2 = ins[25:21]; end
      if (fn >= 6'h18 && fn <= 6'h1B) d = 5'd0;
    end else if (op == 6'h04 || op == 6'h05 || op == 6'h2B) begin
      d = 5'd0;
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op, fn;
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0, 1, 2: op = 6'h00;
      3:       op = 6'h08;
      4:       op = ($urandom_range(0, 2) == 0) ? 6'h04 : (($urandom_range(0, 1) == 0) ? 6'h05 : 6'h2B);
      default: op = 6'($urandom);
    endcase
    case ($urandom_range(0, 8))
      0: fn = 6'h00; 1: fn = 6'h02; 2: fn = 6'h03; 3: fn = 6'h18; 4: fn = 6'h19;
      5: fn = 6'h1A; 6: fn = 6'h1B; 7: fn = 6'h20; default: fn = 6'($urandom);
    endcase
    r = $urandom;
    return {op, 2'b00, r[2:0], 2'b00, r[5:3], r[10:6], r[15:11], fn};
  endfunction

  task automatic test_random;
    logic        exp_valid, exp_ready, acc;
    logic [31:0] exp_instr, exp_gr1, exp_gr2;
    logic [4:0]  s1, s2, exp_dst;
    idle(); rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    exp_valid = 1'b0; exp_instr = '0; exp_gr1 = '0; exp_gr2 = '0; exp_dst = '0; s1 = '0; s2 = '0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = rand_instr();
      wb_en     = $urandom_range(0, 1) == 1;
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      #1;
      exp_ready = !exp_valid || out_ready;
      checks++; if (in_ready !== exp_ready) begin errors++; $display("[TB] FAIL rnd_in_ready c%0d got %b expected %b", c, in_ready, exp_ready); end
      acc = in_valid && exp_ready;
      if (BYP && wb_en && wb_addr != 5'd0) mreg[wb_addr] = wb_data;
      if (acc) begin
        ref_decode(in_instr, s1, s2, exp_dst);
        exp_valid = 1'b1; exp_instr = in_instr;
        exp_gr1 = (s1 == 5'd0) ? 32'd0 : mreg[s1];
        exp_gr2 = (s2 == 5'd0) ? 32'd0 : mreg[s2];
      end else if (out_ready) begin
        exp_valid = 1'b0;
      end else if (BYP && exp_valid) begin
        exp_gr1 = (s1 == 5'd0) ? 32'd0 : mreg[s1];
        exp_gr2 = (s2 == 5'd0) ? 32'd0 : mreg[s2];
      end
      if (!BYP && wb_en && wb_addr != 5'd0) mreg[wb_addr] = wb_data;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid c%0d got %b expected %b", c, out_valid, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (i_datain !== exp_instr || gr1 !== exp_gr1 || gr2 !== exp_gr2 || dst !== exp_dst) begin
          errors++; $display("[TB] FAIL rnd_entry c%0d got %h %h/%h d=%0d expected %h %h/%h d=%0d", c, i_datain, gr1, gr2, dst, exp_instr, exp_gr1, exp_gr2, exp_dst);
        end
      end
    end
    idle(); tick();
  endtask

  initial begin
    rst = 1'b0; in_instr = '0; idle();
    test_reset();
    test_sll();
    test_add();
    test_stall();
    test_r0();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
